// File: rtl/stream_pkg.sv
// Shared types and defaults for the streaming burst reader.
// Contents:
//   state_e        - burst reader FSM state (StIdle, StBurst)
//   DefaultWidth   - default stream data width in bits
//   DefaultCountW  - default width of the FIFO occupancy count
package stream_pkg;

   localparam int unsigned DefaultWidth  = 512;
   localparam int unsigned DefaultCountW = 14;

   typedef enum logic [0:0] {
      StIdle,
      StBurst
   } state_e;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output stage carrying data plus TLAST.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   load        - write a new beat this cycle (caller guarantees slot is free or draining)
//   load_data   - data of the new beat
//   load_last   - TLAST of the new beat
//   ready       - downstream TREADY
//   valid       - TVALID of the held beat
//   data        - TDATA of the held beat
//   last        - TLAST of the held beat
module axis_out_reg #(
   parameter int unsigned WIDTH = 512
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_last,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             last
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             last_q, last_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
         last_d  = load_last;
      end else if (valid_q && ready) begin
         // Data and TLAST are left in place; only the valid flag drops.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;
   assign last  = last_q;

endmodule

// File: rtl/streaming_fifo_burst_reader.sv
// Drains a streaming FIFO in fixed-length bursts and forwards them as an
// AXI-Stream with TLAST. A full burst starts once BURST_LEN beats are
// buffered; a shorter burst of whatever is buffered is flushed after
// TIMEOUT idle cycles (TIMEOUT = 0 disables flushing).
// Ports:
//   ap_clk, ap_rst_n   - clock and asynchronous active-low reset
//   count              - FIFO occupancy
//   in0_V_V_*          - FIFO read side (TREADY is the pop request)
//   out_V_V_*          - burst output stream with TLAST
//   bursts_done        - bursts whose TLAST beat was accepted (wraps)
//   busy               - in a burst or holding an output beat
module streaming_fifo_burst_reader
   import stream_pkg::*;
#(
   parameter int unsigned WIDTH     = DefaultWidth,
   parameter int unsigned COUNT_W   = DefaultCountW,
   parameter int unsigned BURST_LEN = 256,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic               ap_clk,
   input  logic               ap_rst_n,
   input  logic [COUNT_W-1:0] count,
   input  logic [WIDTH-1:0]   in0_V_V_TDATA,
   input  logic               in0_V_V_TVALID,
   output logic               in0_V_V_TREADY,
   output logic [WIDTH-1:0]   out_V_V_TDATA,
   output logic               out_V_V_TVALID,
   input  logic               out_V_V_TREADY,
   output logic               out_V_V_TLAST,
   output logic [31:0]        bursts_done,
   output logic               busy
);

   localparam int unsigned          IdleW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [COUNT_W-1:0]   BurstLenC = COUNT_W'(BURST_LEN);
   localparam logic [IdleW-1:0]     IdleLast  = IdleW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [COUNT_W-1:0] beats_left_q, beats_left_d;
   logic [IdleW-1:0]   idle_cnt_q, idle_cnt_d;
   logic [31:0]        bursts_done_q, bursts_done_d;

   logic full_avail;
   logic partial_avail;
   logic timeout_hit;
   logic pop;
   logic load_last;
   logic out_done;

   assign full_avail    = (count >= BurstLenC);
   assign partial_avail = (count != '0) && (count < BurstLenC);
   assign timeout_hit   = (TIMEOUT != 0) && (idle_cnt_q == IdleLast);
   assign out_done      = out_V_V_TVALID && out_V_V_TREADY && out_V_V_TLAST;

   // State register.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q       <= StIdle;
         beats_left_q  <= '0;
         idle_cnt_q    <= '0;
         bursts_done_q <= '0;
      end else begin
         state_q       <= state_d;
         beats_left_q  <= beats_left_d;
         idle_cnt_q    <= idle_cnt_d;
         bursts_done_q <= bursts_done_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d       = state_q;
      beats_left_d  = beats_left_q;
      idle_cnt_d    = idle_cnt_q;
      bursts_done_d = bursts_done_q + 32'(out_done);
      unique case (state_q)
         StIdle: begin
            if (full_avail) begin
               state_d      = StBurst;
               beats_left_d = BurstLenC;
               idle_cnt_d   = '0;
            end else if (partial_avail) begin
               if (timeout_hit) begin
                  // count only reflects beats already written, so the
                  // snapshot can never underflow the FIFO.
                  state_d      = StBurst;
                  beats_left_d = count;
                  idle_cnt_d   = '0;
               end else begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end else begin
               idle_cnt_d = '0;
            end
         end
         StBurst: begin
            if (pop) begin
               beats_left_d = beats_left_q - 1'b1;
               if (beats_left_q == COUNT_W'(1)) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs.
   always_comb begin
      in0_V_V_TREADY = (state_q == StBurst) && (beats_left_q != '0) &&
                       (!out_V_V_TVALID || out_V_V_TREADY);
      pop            = in0_V_V_TREADY && in0_V_V_TVALID;
      load_last      = (beats_left_q == COUNT_W'(1));
      busy           = (state_q == StBurst) || out_V_V_TVALID;
   end

   assign bursts_done = bursts_done_q;

   axis_out_reg #(
      .WIDTH(WIDTH)
   ) u_out_reg (
      .clk      (ap_clk),
      .rst_n    (ap_rst_n),
      .load     (pop),
      .load_data(in0_V_V_TDATA),
      .load_last(load_last),
      .ready    (out_V_V_TREADY),
      .valid    (out_V_V_TVALID),
      .data     (out_V_V_TDATA),
      .last     (out_V_V_TLAST)
   );

endmodule

// File: tb/tb_streaming_fifo_burst_reader.sv
// Directed bench for streaming_fifo_burst_reader with a small FIFO model on
// the input side and a beat recorder on the output side.
module tb_streaming_fifo_burst_reader;

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 8;
   localparam int unsigned BL = 4;
   localparam int unsigned TO = 16;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n = 1'b0;
   logic [CW-1:0] count;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_last;
   logic [31:0]   bursts_done;
   logic          busy;

   always #5 ap_clk = ~ap_clk;

   streaming_fifo_burst_reader #(
      .WIDTH    (W),
      .COUNT_W  (CW),
      .BURST_LEN(BL),
      .TIMEOUT  (TO)
   ) dut (
      .ap_clk        (ap_clk),
      .ap_rst_n      (ap_rst_n),
      .count         (count),
      .in0_V_V_TDATA (in_data),
      .in0_V_V_TVALID(in_valid),
      .in0_V_V_TREADY(in_ready),
      .out_V_V_TDATA (out_data),
      .out_V_V_TVALID(out_valid),
      .out_V_V_TREADY(out_ready),
      .out_V_V_TLAST (out_last),
      .bursts_done   (bursts_done),
      .busy          (busy)
   );

   // FIFO model: written by the stimulus process, popped on handshakes.
   logic [W-1:0] mem [0:255];
   int unsigned  wr_ptr = 0;
   int unsigned  rd_ptr = 0;
   logic         fifo_clear = 1'b0;

   assign count    = CW'(wr_ptr - rd_ptr);
   assign in_data  = mem[rd_ptr[7:0]];
   assign in_valid = (count != '0);

   int unsigned  pops = 0;
   int unsigned  cyc = 0;
   int unsigned  out_n = 0;
   logic [W-1:0] cap_data [0:255];
   logic         cap_last [0:255];
   int unsigned  cap_cyc  [0:255];

   always @(posedge ap_clk) begin
      cyc <= cyc + 1;
      if (fifo_clear) begin
         rd_ptr <= wr_ptr;
      end else if (in_ready && in_valid) begin
         rd_ptr <= rd_ptr + 1;
         pops   <= pops + 1;
      end
      if (out_valid && out_ready) begin
         cap_data[out_n[7:0]] <= out_data;
         cap_last[out_n[7:0]] <= out_last;
         cap_cyc[out_n[7:0]]  <= cyc;
         out_n                <= out_n + 1;
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [W-1:0] d);
      mem[wr_ptr[7:0]] = d;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge ap_clk);
         #1;
      end
   endtask

   task automatic wait_outs(input int unsigned target, input string tag);
      int unsigned n = 0;
      while (out_n < target && n < 200) begin
         tick(1);
         n++;
      end
      check_eq(tag, 32'(out_n >= target), 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_tvalid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_tlast"}, 32'(out_last), 32'd0);
      check_eq({tag, "_tdata"}, out_data, 32'd0);
      check_eq({tag, "_tready"}, 32'(in_ready), 32'd0);
      check_eq({tag, "_bursts"}, bursts_done, 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base;
      int unsigned snap;
      int unsigned n;
      int unsigned exp_bd;

      exp_bd = 0;

      // Reset state.
      #2;
      check_idle_outputs("reset");
      tick(2);
      ap_rst_n = 1'b1;
      tick(2);

      // Full burst of 4 on consecutive cycles.
      base = out_n;
      for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
      wait_outs(base + 4, "full_done");
      tick(2);
      for (int i = 0; i < 4; i++) begin
         check_eq("full_data", cap_data[base + i], 32'hA0 + 32'(i));
         check_eq("full_last", 32'(cap_last[base + i]), 32'(i == 3));
         check_eq("full_cycle", cap_cyc[base + i] - cap_cyc[base], 32'(i));
      end
      exp_bd = 1;
      check_eq("full_bursts", bursts_done, exp_bd);
      check_eq("full_busy", 32'(busy), 32'd0);

      // Backpressure on beat 2 for three cycles.
      base = out_n;
      for (int i = 0; i < 4; i++) push(32'hB0 + 32'(i));
      n = 0;
      while (!(out_valid && out_data == 32'hB1) && n < 50) begin
         tick(1);
         n++;
      end
      check_eq("bp_found", 32'(n < 50), 32'd1);
      out_ready = 1'b0;
      snap = pops;
      repeat (3) begin
         tick(1);
         check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
         check_eq("bp_hold_data", out_data, 32'hB1);
         check_eq("bp_hold_last", 32'(out_last), 32'd0);
      end
      check_eq("bp_no_pop", pops - snap, 32'd0);
      out_ready = 1'b1;
      wait_outs(base + 4, "bp_done");
      tick(2);
      for (int i = 0; i < 4; i++) begin
         check_eq("bp_data", cap_data[base + i], 32'hB0 + 32'(i));
         check_eq("bp_last", 32'(cap_last[base + i]), 32'(i == 3));
      end
      exp_bd = 2;
      check_eq("bp_bursts", bursts_done, exp_bd);

      // Timeout flush of a 3-beat partial burst.
      base = out_n;
      for (int i = 0; i < 3; i++) push(32'hC0 + 32'(i));
      n = 0;
      while (!in_ready && n < 100) begin
         tick(1);
         n++;
      end
      check_eq("flush_ready_edge", n, TO);
      wait_outs(base + 3, "flush_done");
      tick(2);
      for (int i = 0; i < 3; i++) begin
         check_eq("flush_data", cap_data[base + i], 32'hC0 + 32'(i));
         check_eq("flush_last", 32'(cap_last[base + i]), 32'(i == 2));
      end
      exp_bd = 3;
      check_eq("flush_bursts", bursts_done, exp_bd);

      // Full burst wins when count fills on the timeout cycle.
      base = out_n;
      push(32'hD0);
      tick(15);
      check_eq("prio_not_yet", 32'(in_ready), 32'd0);
      for (int i = 1; i < 5; i++) push(32'hD0 + 32'(i));
      tick(1);
      check_eq("prio_start", 32'(in_ready), 32'd1);
      wait_outs(base + 4, "prio_done");
      tick(2);
      for (int i = 0; i < 4; i++) begin
         check_eq("prio_data", cap_data[base + i], 32'hD0 + 32'(i));
         check_eq("prio_last", 32'(cap_last[base + i]), 32'(i == 3));
      end
      check_eq("prio_left", 32'(count), 32'd1);
      exp_bd = 4;
      check_eq("prio_bursts", bursts_done, exp_bd);
      wait_outs(base + 5, "prio_tail_done");
      tick(2);
      check_eq("prio_tail_data", cap_data[base + 4], 32'hD4);
      check_eq("prio_tail_last", 32'(cap_last[base + 4]), 32'd1);
      exp_bd = 5;
      check_eq("prio_tail_bursts", bursts_done, exp_bd);

      // Back-to-back bursts from 8 buffered beats.
      base = out_n;
      for (int i = 0; i < 8; i++) push(32'hE0 + 32'(i));
      wait_outs(base + 8, "b2b_done");
      tick(2);
      for (int i = 0; i < 8; i++) begin
         check_eq("b2b_data", cap_data[base + i], 32'hE0 + 32'(i));
         check_eq("b2b_last", 32'(cap_last[base + i]), 32'(i == 3 || i == 7));
      end
      check_eq("b2b_first_span", cap_cyc[base + 3] - cap_cyc[base], 32'd3);
      check_eq("b2b_gap", cap_cyc[base + 4] - cap_cyc[base + 3], 32'd2);
      exp_bd = 7;
      check_eq("b2b_bursts", bursts_done, exp_bd);

      // Reset after two of four beats.
      base = out_n;
      for (int i = 0; i < 4; i++) push(32'hF0 + 32'(i));
      wait_outs(base + 2, "rst_two_beats");
      ap_rst_n = 1'b0;
      #1;
      check_idle_outputs("rst_mid");
      fifo_clear = 1'b1;
      tick(1);
      fifo_clear = 1'b0;
      check_eq("rst_fifo_clear", 32'(count), 32'd0);
      tick(1);
      ap_rst_n = 1'b1;
      tick(3);
      check_idle_outputs("rst_after");
      check_eq("rst_no_more_outs", out_n - base, 32'd2);
      base = out_n;
      for (int i = 0; i < 4; i++) push(32'h10 + 32'(i));
      wait_outs(base + 4, "rst_resume_done");
      tick(2);
      for (int i = 0; i < 4; i++) begin
         check_eq("rst_resume_data", cap_data[base + i], 32'h10 + 32'(i));
         check_eq("rst_resume_last", 32'(cap_last[base + i]), 32'(i == 3));
      end
      check_eq("rst_resume_bursts", bursts_done, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
